dmem_lsu: RTL

//  Load/store initiator that sits between the CPU execute stage and dmem.
//  - Accepts one load or store request at a time from the CPU.
//  - Performs byte, half and word accesses against dmem, which reads a whole

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_lane_unit.sv | 39 +++
 rtl/dmem_lsu.sv | 114 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the dmem load/store path: access size codes, LSU states and lane widths.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_BAD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MERGE,
    ST_WRITE,
    ST_RESP
  } state_e;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned WORD_W = 32;

endpackage

// File: rtl/dmem_lane_unit.sv
// Little-endian lane logic: extracts and extends load lanes, merges sub-word store data into a word.
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        addr,
  input  size_e             size,
  input  logic              sgn,
  input  logic [HALF_W-1:0] wdata,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] merged
);

  logic [BYTE_W-1:0] lane_b;
  logic [HALF_W-1:0] lane_h;

  always_comb begin
    lane_b = word[{addr, 3'b000} +: BYTE_W];
    lane_h = addr[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    load_data = {{(WORD_W - BYTE_W){sgn & lane_b[BYTE_W-1]}}, lane_b};
      SZ_H:    load_data = {{(WORD_W - HALF_W){sgn & lane_h[HALF_W-1]}}, lane_h};
      default: load_data = word;
    endcase
  end

  always_comb begin
    merged = word;
    case (size)
      SZ_B: merged[{addr, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
      SZ_H: begin
        if (addr[1]) merged[31:16] = wdata;
        else         merged[15:0]  = wdata;
      end
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator between the CPU execute stage and a word-wide dmem; sub-word stores use RMW.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e      state;
  logic        store_q;
  logic        signed_q;
  size_e       size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merged_q;
  logic [31:0] rdata_q;
  logic        err_q;

  size_e       req_sz;
  logic        req_err;
  logic [31:0] lane_load;
  logic [31:0] lane_merged;

  always_comb begin
    req_sz  = size_e'(req_size);
    req_err = (req_sz == SZ_BAD)
            | ((req_sz == SZ_H) & req_addr[0])
            | ((req_sz == SZ_W) & (req_addr[1:0] != 2'b00))
            | ((req_addr >> ADDR_W) != '0);
  end

  dmem_lane_unit u_lane (
    .word      (mem_rdata),
    .addr      (addr_q[1:0]),
    .size      (size_q),
    .sgn       (signed_q),
    .wdata     (wdata_q[HALF_W-1:0]),
    .load_data (lane_load),
    .merged    (lane_merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      store_q  <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= SZ_B;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            store_q  <= req_store;
            signed_q <= req_signed;
            size_q   <= req_sz;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rdata_q  <= '0;
            err_q    <= req_err;
            if (req_err)             state <= ST_RESP;
            else if (!req_store)     state <= ST_LOAD;
            else if (req_sz == SZ_W) state <= ST_WRITE;
            else                     state <= ST_MERGE;
          end
        end
        ST_LOAD: begin
          rdata_q <= lane_load;
          state   <= ST_RESP;
        end
        ST_MERGE: begin
          merged_q <= lane_merged;
          state    <= ST_WRITE;
        end
        ST_WRITE: state <= ST_RESP;
        ST_RESP:  if (resp_ready) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Gating with rst lets a reset landing in the WRITE cycle cancel the store.
  assign mem_we     = (state == ST_WRITE) & !rst;
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = (size_q == SZ_W) ? wdata_q : merged_q;
  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  logic unused_store;
  assign unused_store = store_q;

endmodule
